// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants, state encoding and frame length; UART_TX_PARITY_EN adds the even parity bit
package uart_pkg;
  localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_e;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_e;
`endif
  function automatic int frame_len(input int n);
    return n * FRAME_BITS;
  endfunction
endpackage

// File: rtl/tx_baud_cnt.sv
// tx_baud_cnt: mod-N bit-period counter with enable and synchronous clear, one-cycle tick on wrap
module tx_baud_cnt #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(N);
  logic [W-1:0] cnt_q;
  assign tick_o = en_i && cnt_q == W'(N - 1);
  // count 0..N-1 while enabled, restart from 0 on clear
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= tick_o ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: RS232 transmitter, LSB first, 8N1 (8E1 when UART_TX_PARITY_EN is defined)
module uart_tx import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       eot_o
);
  localparam int N = CLK_FREQ / BAUD_RATE;
  state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic tx_q, tx_d, busy_q, busy_d, eot_q, eot_d, tick, idle;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign idle = state_q == IDLE;
  assign tx_o = tx_q;
  assign busy_o = busy_q;
  assign eot_o = eot_q;
  tx_baud_cnt #(.N(N)) u_baud (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!idle),
    .clr_i (idle),
    .tick_o(tick)
  );
  // next state, shift/bit counter updates; outputs derived from the next state so they are registered
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        state_d = START;
        shift_d = data_i;
        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
        par_d = ^data_i;
`endif
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
    busy_d = state_d != IDLE;
    eot_d = state_d == IDLE;
  end
  // state and output registers, reset returns the line to idle immediately
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      eot_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      eot_q <= eot_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

RS232 transmitter. It serializes one byte per request onto a single line in 8N1 format, or 8E1 when parity is compiled in, sending the LSB first at a parameterized baud rate. It is the transmit end of the board's RS232 link and drives the FPGA TX pin directly. Its request/done handshake mirrors the receive side's end-of-reception flag.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- The bit period is N = CLK_FREQ / BAUD_RATE clock cycles, truncated by integer division. N must be ≥ 2.

Ports:
- clk_i, input, 1, system clock; all logic on the rising edge.
- rst_i, input, 1, reset. One clock; reset is asynchronous and active-high.
- data_i, input, 8, byte to send. Sampled only when a request is accepted.
- start_i, input, 1, transmit request. A level check is done each cycle.
- tx_o, output, 1, serial line; idles high.
- busy_o, output, 1, high while a frame is in progress.
- eot_o, output, 1, end of transmission; high when idle and ready.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - Outputs are tx_o=1, busy_o=0, eot_o=1.
  - If start_i=1, latch data_i into the shift register, clear the bit counter and the baud counter, and go to START.
- START: tx_o=0 for N cycles, then go to DATA.
- DATA: tx_o = shift_reg[0] for N cycles per bit. At each bit end, shift right and increment the bit counter. After the 8th bit, go to PARITY if enabled, otherwise STOP.
- PARITY: tx_o = XOR of the latched byte (even parity) for N cycles, then go to STOP.
- STOP: tx_o=1 for N cycles, then go to IDLE.
- In every state other than IDLE: busy_o=1 and eot_o=0.
- start_i is ignored while busy. data_i changes during a frame have no effect.
- Baud counter width is $clog2(N). It counts 0..N-1, wraps at N-1, and raises the bit-end tick on that wrap. It runs only outside IDLE.
- The bit counter is 3 bits. The DATA exit is taken on the tick when the count equals 7.
- tx_o, busy_o and eot_o are registered; there are no combinational paths from inputs.
- Reset, at any time including mid-frame:
  - The state goes to IDLE immediately (asynchronously).
  - tx_o=1, busy_o=0, eot_o=1.
  - Counters and the shift register are cleared to 0.
  - A partially sent frame is abandoned; the line returns high without a stop-bit guarantee.

## Timing
- Cycle 0 is the cycle in which start_i=1 is sampled in IDLE.
- tx_o=0 from cycle 1 through cycle N (start bit).
- Data bit k (k=0..7) is on tx_o for cycles 1+(k+1)·N through (k+2)·N.
- Parity bit (if enabled) occupies cycles 1+9N through 10N.
- Stop bit occupies the next N cycles.
- Frame length is F = 10N cycles (11N with parity). busy_o=1 for cycles 1..F.
- eot_o drops at cycle 1 and returns high at cycle F+1.
- Back-to-back: a start_i held high, or asserted in cycle F+1, starts the next frame with its start bit at cycle F+2. The guaranteed minimum gap between frames is one idle cycle.
- Latency from request to the line falling is 1 cycle.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state exists and frames carry an even parity bit after D7. F = 11N.
- UART_TX_PARITY_EN undefined: no parity logic is compiled and there is no PARITY state. DATA goes straight to STOP. F = 10N.
- The macro is shared with the receiver so both ends agree on the frame format.

## Structure
- uart_pkg holds:
  - State encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits.
  - DATA_BITS=8.
  - A frame-length helper constant.
- Sub-module tx_baud_cnt contains the mod-N counter with enable and synchronous clear, producing a 1-cycle tick.
- uart_tx contains the FSM, the 8-bit shift register and the bit counter.

## Test plan
Every scenario below uses CLK_FREQ=1000 and BAUD_RATE=100, so N=10.
- Reset: assert rst_i mid-frame while a 0xFF byte is in its data bits. tx_o must be 1, busy_o 0 and eot_o 1 in the same cycle, with no further transitions.
- Single byte 0x55, parity off: tx_o reads start 0, then 1,0,1,0,1,0,1,0, then 1, each held exactly 10 cycles. busy_o is high for 100 cycles and eot_o rises at cycle 101.
- Byte 0xA3 with UART_TX_PARITY_EN defined: data bits are 1,1,0,0,0,1,0,1, then parity 0 (four ones), then stop. The frame lasts 110 cycles.
- Byte 0x07 with parity enabled: the parity bit is 1 (three ones).
- start_i pulsed again at cycle 37 with data_i=0x00 during a 0x55 frame: the request is ignored and the frame is bit-exact 0x55.
- start_i held high with data_i 0x12 then 0x34: two frames, the second start bit at cycle 102, with exactly one idle-high cycle between the stop bit and the next start bit.
